// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, states, datapath
// mux selects and the bundled control word.
package multicycle_control_pkg;

    localparam logic [3:0] OP_ALU_R  = 4'h0;
    localparam logic [3:0] OP_ALU_I  = 4'h1;
    localparam logic [3:0] OP_LOAD   = 4'h2;
    localparam logic [3:0] OP_STORE  = 4'h3;
    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_JUMP   = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_e;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_ONE    = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       iw;
        logic       fu;
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/control_decode.sv
// State-to-control-word decode. Only FETCH (MemReady) and BRANCH (Perform)
// fold an input into a strobe; everything else is a pure function of state.
import multicycle_control_pkg::*;

module control_decode (
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   perform_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NONE;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.iw        = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.fu        = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_source = PCSRC_ALUOUT;
                ctrl_o.pc_write  = perform_i;
            end
            S_JUMP: begin
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.pc_write  = 1'b1;
            end
            S_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: ctrl_o = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: state register and next-state logic,
// with the output decode delegated to control_decode.
import multicycle_control_pkg::*;

module multicycle_control (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Op,
    input  logic       Perform,
    input  logic       MemReady,
    output logic       IW,
    output logic       FU,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Halted,
    output logic [3:0] State
);

    state_e state_q, state_d;
    ctrl_t  dec_ctrl, ctrl;

    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Op is only looked at in DECODE and MEM_ADDR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_ALU_R:           state_d = S_EXEC_R;
                    OP_ALU_I:           state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JUMP:            state_d = S_JUMP;
                    OP_HALT:            state_d = S_HALT;
                    default:            state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (Op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (MemReady) state_d = S_MEM_WB;
            S_MEM_WR:   if (MemReady) state_d = S_FETCH;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    control_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (MemReady),
        .perform_i   (Perform),
        .ctrl_o      (dec_ctrl)
    );

    // Reset blanks every output, even though the register only updates on the edge.
    assign ctrl  = Reset ? CTRL_NONE : dec_ctrl;
    assign State = Reset ? 4'd0 : state_q;

    assign IW       = ctrl.iw;
    assign FU       = ctrl.fu;
    assign PCWrite  = ctrl.pc_write;
    assign IorD     = ctrl.iord;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign RegWrite = ctrl.reg_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSource = ctrl.pc_source;
    assign Halted   = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and output-word checks.
module tb_multicycle_control;

    logic       CLK = 1'b0;
    logic       Reset, Perform, MemReady;
    logic [3:0] Op;
    logic       IW, FU, PCWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, ALUSrcA, Halted;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int checks = 0;
    int failures = 0;

    multicycle_control dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .Perform(Perform), .MemReady(MemReady),
        .IW(IW), .FU(FU), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .Halted(Halted), .State(State)
    );

    always #5 CLK = ~CLK;

    // {IW,FU,PCWrite,IorD,MemRead,MemWrite,RegWrite,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSource,Halted}
    logic [15:0] outs;
    assign outs = {IW, FU, PCWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted};

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
                           MADDR = 4'd4, MRD = 4'd5, MWB = 4'd6, MWR = 4'd7,
                           ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, HALT = 4'd11;

    localparam logic [15:0] O_NONE    = 16'h0000;
    localparam logic [15:0] O_FETCH   = 16'hA820;
    localparam logic [15:0] O_FSTALL  = 16'h0820;
    localparam logic [15:0] O_DECODE  = 16'h0060;
    localparam logic [15:0] O_EXEC_R  = 16'h0090;
    localparam logic [15:0] O_EXEC_I  = 16'h00D0;
    localparam logic [15:0] O_ALUWB   = 16'h4200;
    localparam logic [15:0] O_MADDR   = 16'h00C0;
    localparam logic [15:0] O_MRD     = 16'h1800;
    localparam logic [15:0] O_MWB     = 16'h0300;
    localparam logic [15:0] O_MWR     = 16'h1400;
    localparam logic [15:0] O_BR_NT   = 16'h008A;
    localparam logic [15:0] O_BR_T    = 16'h208A;
    localparam logic [15:0] O_JUMP    = 16'h2004;
    localparam logic [15:0] O_HALT    = 16'h0001;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check state and outputs mid-cycle, advance a clock.
    task automatic cyc(input string tag, input logic rst, input logic [3:0] op,
                       input logic perf, input logic rdy,
                       input logic [3:0] exp_state, input logic [15:0] exp_outs);
        Reset = rst; Op = op; Perform = perf; MemReady = rdy;
        #1;
        chk({tag, ".state"}, 32'(State), 32'(exp_state));
        chk({tag, ".outs"}, 32'(outs), 32'(exp_outs));
        @(posedge CLK); #2;
    endtask

    initial begin
        Reset = 1'b1; Op = 4'h0; Perform = 1'b1; MemReady = 1'b1;
        @(posedge CLK); #2;
        cyc("rst0", 1, 4'h0, 1, 1, FETCH, O_NONE);
        cyc("rst1", 1, 4'h0, 1, 1, FETCH, O_NONE);

        // ALU-R: IW in cycle 1, writeback in cycle 4, FETCH in cycle 5
        cyc("aluR.c1", 0, 4'h0, 0, 1, FETCH,  O_FETCH);
        cyc("aluR.c2", 0, 4'h0, 0, 1, DECODE, O_DECODE);
        cyc("aluR.c3", 0, 4'h7, 0, 1, EXEC_R, O_EXEC_R);
        cyc("aluR.c4", 0, 4'h7, 0, 1, ALUWB,  O_ALUWB);

        // ALU-I with a fetch stall first
        cyc("aluI.stall", 0, 4'h1, 0, 0, FETCH,  O_FSTALL);
        cyc("aluI.c1",    0, 4'h1, 0, 1, FETCH,  O_FETCH);
        cyc("aluI.c2",    0, 4'h1, 0, 1, DECODE, O_DECODE);
        cyc("aluI.c3",    0, 4'h1, 0, 1, EXEC_I, O_EXEC_I);
        cyc("aluI.c4",    0, 4'h1, 0, 1, ALUWB,  O_ALUWB);

        // LOAD with 3 stall cycles in MEM_RD
        cyc("ld.c1",  0, 4'h2, 0, 1, FETCH,  O_FETCH);
        cyc("ld.c2",  0, 4'h2, 0, 1, DECODE, O_DECODE);
        cyc("ld.c3",  0, 4'h2, 0, 1, MADDR,  O_MADDR);
        cyc("ld.s1",  0, 4'h2, 0, 0, MRD,    O_MRD);
        cyc("ld.s2",  0, 4'h3, 0, 0, MRD,    O_MRD);
        cyc("ld.s3",  0, 4'h3, 0, 0, MRD,    O_MRD);
        cyc("ld.rdy", 0, 4'h3, 0, 1, MRD,    O_MRD);
        cyc("ld.wb",  0, 4'h3, 0, 1, MWB,    O_MWB);

        // STORE; Op before DECODE is irrelevant
        cyc("st.c1", 0, 4'h9, 0, 1, FETCH,  O_FETCH);
        cyc("st.c2", 0, 4'h3, 0, 1, DECODE, O_DECODE);
        cyc("st.c3", 0, 4'h3, 0, 1, MADDR,  O_MADDR);
        cyc("st.c4", 0, 4'h2, 0, 1, MWR,    O_MWR);

        // BRANCH not taken, then taken
        cyc("brn.c1", 0, 4'h4, 1, 1, FETCH,  O_FETCH);
        cyc("brn.c2", 0, 4'h4, 1, 1, DECODE, O_DECODE);
        cyc("brn.c3", 0, 4'h4, 0, 1, BRANCH, O_BR_NT);
        cyc("brt.c1", 0, 4'h4, 0, 1, FETCH,  O_FETCH);
        cyc("brt.c2", 0, 4'h4, 0, 1, DECODE, O_DECODE);
        cyc("brt.c3", 0, 4'h4, 1, 1, BRANCH, O_BR_T);

        // JUMP
        cyc("jmp.c1", 0, 4'h5, 0, 1, FETCH,  O_FETCH);
        cyc("jmp.c2", 0, 4'h5, 0, 1, DECODE, O_DECODE);
        cyc("jmp.c3", 0, 4'h5, 0, 1, JUMP,   O_JUMP);

        // Illegal opcode: DECODE straight back to FETCH
        cyc("ill.c1", 0, 4'h9, 1, 1, FETCH,  O_FETCH);
        cyc("ill.c2", 0, 4'h9, 1, 1, DECODE, O_DECODE);
        cyc("ill.c3", 0, 4'h9, 1, 1, FETCH,  O_FETCH);

        // Reset in the middle of a stalled store
        cyc("rwr.c2", 0, 4'h3, 1, 1, DECODE, O_DECODE);
        cyc("rwr.c3", 0, 4'h3, 1, 1, MADDR,  O_MADDR);
        cyc("rwr.c4", 0, 4'h3, 1, 0, MWR,    O_MWR);
        cyc("rwr.rst", 1, 4'h3, 1, 0, FETCH, O_NONE);
        cyc("rwr.post", 0, 4'h3, 1, 0, FETCH, O_FSTALL);

        // HALT absorbs despite Op churn, exits only on Reset
        cyc("hlt.c1", 0, 4'hF, 1, 1, FETCH,  O_FETCH);
        cyc("hlt.c2", 0, 4'hF, 1, 1, DECODE, O_DECODE);
        for (int i = 0; i < 10; i++)
            cyc($sformatf("hlt.h%0d", i), 0, 4'(i), 1, 1, HALT, O_HALT);
        cyc("hlt.rst", 1, 4'h0, 1, 1, FETCH, O_NONE);
        cyc("hlt.post", 0, 4'h0, 1, 1, FETCH, O_FETCH);
        cyc("hlt.dec", 0, 4'h0, 1, 1, DECODE, O_DECODE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
